register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised successor to the ID-stage register file. It provides NR synchronous read ports, one write port, a hardwired zero register and a write-through bypass. It adds a handshaked dump engine that streams every register to the debug unit over valid/ready, while the pipeline keeps reading and writing.

Parameters:
B, 32, data width in bits
W, 5, address width; depth = 2**W registers
NR, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is a normal register

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_reg_write_MC  in  1  write enable (RegWrite control line)
i_write_register  in  W  write address
i_write_data  in  B  write data
i_read_regs  in  NR*W  read addresses, port k at bits [k*W +: W]
o_read_data  out  NR*B  read data, port k at bits [k*B +: B]
i_dump_start  in  1  one-cycle request to start a full-register dump
i_dump_ready  in  1  debug consumer ready
o_dump_valid  out  1  dump beat valid
o_dump_addr  out  W  register index of the current beat
o_dump_data  out  B  register contents of the current beat
o_dump_busy  out  1  high in DUMP state
o_dump_done  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - all registers = 0
  - o_read_data = 0; o_dump_valid = 0; o_dump_addr = 0; o_dump_busy = 0; o_dump_done = 0
  - dump FSM goes to IDLE
- Write:
  - at a rising edge with i_reg_write_MC=1, regs[i_write_register] <= i_write_data
  - with ZERO_REG=1, writes to address 0 are discarded
- Read:
  - each port k registers regs[addr_k] at the rising edge; latency 1 cycle
  - with ZERO_REG=1, address 0 always returns 0
  - same-cycle write to the same address: see Optional Feature
- Ports are independent; any number may read the same address.
- Dump FSM, states IDLE, DUMP, DONE:
  - IDLE: i_dump_start=1 -> DUMP, pointer = 0. In any other state i_dump_start is ignored.
  - DUMP:
    - o_dump_valid=1, o_dump_addr=pointer
    - o_dump_data = current regs[pointer], combinational from the array (0 for index 0 when ZERO_REG=1)
    - a beat transfers when valid && ready; the pointer then increments
    - data and address stay stable while ready=0
    - transfer at pointer = 2**W-1 -> DONE
  - DONE: o_dump_done=1 for exactly one cycle, o_dump_valid=0, then -> IDLE
- Writes during a dump:
  - a write to a register already dumped is not re-sent
  - a write landing at the same edge as that register's transfer: the consumer sees the pre-write value
- Reset during DUMP or DONE aborts the dump immediately; no done pulse.
- Total dump length with ready held high: 2**W beats, done pulse in cycle 2**W+1 after the start cycle.

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined: if i_reg_write_MC=1, the write is not discarded by ZERO_REG, and i_write_register equals read address k in the same cycle, then port k registers i_write_data (new value, write-through). This replaces the negedge-read scheme.
- Undefined: port k registers the old array value. The pipeline must then stall or forward externally.
- The dump path is unaffected either way.

Test Plan:
- Reset mid-activity: drive i_reset_n=0 asynchronously between edges -> o_read_data=0 and o_dump_valid=0 immediately; every register reads 0 afterwards.
- Write then read: write 0xDEADBEEF to r5; next cycle read r5 on both ports -> 0xDEADBEEF on each port one cycle after the address is presented.
- Zero register: ZERO_REG=1, write 0x12345678 to r0 -> r0 reads 0; rebuild with ZERO_REG=0 -> r0 reads 0x12345678.
- Collision: write 0xA5A5A5A5 to r7 while port 0 reads r7 (old value 0x11) -> 0xA5A5A5A5 with REGFILE_WRITE_BYPASS_EN, 0x11 without it.
- Dump with backpressure: preload regs[i]=i*3; start the dump; toggle i_dump_ready every other cycle -> 2**W beats, addresses 0..31 in order, data i*3, no beat lost or duplicated, one o_dump_done pulse; an i_dump_start during DUMP is ignored.
- Abort: assert reset after beat 10 of a dump -> FSM IDLE, no done pulse; a new start afterwards dumps from address 0.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Debug dump channel of register_file_mp: start request, valid/ready beat stream, status.
// master = debug unit (requests and consumes), slave = register file (streams registers).
interface register_file_mp_if #(
    parameter int B = 32,
    parameter int W = 5
);
    logic         dump_start;
    logic         dump_ready;
    logic         dump_valid;
    logic [W-1:0] dump_addr;
    logic [B-1:0] dump_data;
    logic         dump_busy;
    logic         dump_done;

    modport master (
        output dump_start, dump_ready,
        input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  dump_start, dump_ready,
        output dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port ID-stage register file with zero register and a valid/ready full-register dump engine.
// Optional REGFILE_WRITE_BYPASS_EN: same-cycle write to a read address is passed through to that port.
module register_file_mp #(
    parameter int B        = 32,
    parameter int W        = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_reg_write_MC,
    input  logic [W-1:0]    i_write_register,
    input  logic [B-1:0]    i_write_data,
    input  logic [NR*W-1:0] i_read_regs,
    output logic [NR*B-1:0] o_read_data,
    register_file_mp_if.slave dump
);
    localparam int           DEPTH = 2 ** W;
    localparam logic [W-1:0] LAST  = W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } dump_state_t;

    logic [B-1:0]    regs [DEPTH];
    logic            wr_en;
    logic [NR*B-1:0] rd_next;

    dump_state_t     state;
    logic [W-1:0]    ptr;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;

    assign wr_en = i_reg_write_MC && !(ZERO_REG != 0 && i_write_register == '0);

    // NOTE: the array is reset because every register's post-reset value (0) is architecturally visible.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: non-blocking so every read of regs at this edge still sees the old contents.
            regs[i_write_register] <= i_write_data;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the loop leaves rd_next unassigned (no latch).
        rd_next = '0;
        for (int k = 0; k < NR; k++) begin
            rd_next[k*B +: B] = regs[i_read_regs[k*W +: W]];
            if (ZERO_REG != 0 && i_read_regs[k*W +: W] == '0) begin
                rd_next[k*B +: B] = '0;
            end
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wr_en && i_write_register == i_read_regs[k*W +: W]) begin
                rd_next[k*B +: B] = i_write_data;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_read_data <= '0;
        end else begin
            o_read_data <= rd_next;
        end
    end

    // Dump engine: valid is held for the whole DUMP state, so a beat moves whenever ready is high.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump.dump_start) begin
                        state   <= DUMP;
                        ptr     <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                DUMP: begin
                    if (dump.dump_ready) begin
                        if (ptr == LAST) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Beat data comes straight from the array: a write at the transfer edge is not yet visible.
    always_comb begin
        dump.dump_data = regs[ptr];
        if (ZERO_REG != 0 && ptr == '0) begin
            dump.dump_data = '0;
        end
    end

    assign dump.dump_valid = valid_q;
    assign dump.dump_addr  = ptr;
    assign dump.dump_busy  = busy_q;
    assign dump.dump_done  = done_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp; a second instance with ZERO_REG=0 shares the write/read stimulus.
module tb_register_file_mp;
    localparam int B     = 32;
    localparam int W     = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 2 ** W;

    logic            i_clk     = 1'b0;
    logic            i_reset_n = 1'b1;
    logic            we        = 1'b0;
    logic [W-1:0]    waddr     = '0;
    logic [B-1:0]    wdata     = '0;
    logic [NR*W-1:0] raddr     = '0;
    logic [NR*B-1:0] rdata;
    logic [NR*B-1:0] rdata_nz;

    int checks = 0;
    int errors = 0;

    register_file_mp_if #(.B(B), .W(W)) dif ();
    register_file_mp_if #(.B(B), .W(W)) dif_nz ();

    register_file_mp #(.B(B), .W(W), .NR(NR), .ZERO_REG(1)) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_reg_write_MC   (we),
        .i_write_register (waddr),
        .i_write_data     (wdata),
        .i_read_regs      (raddr),
        .o_read_data      (rdata),
        .dump             (dif)
    );

    register_file_mp #(.B(B), .W(W), .NR(NR), .ZERO_REG(0)) dut_nz (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_reg_write_MC   (we),
        .i_write_register (waddr),
        .i_write_data     (wdata),
        .i_read_regs      (raddr),
        .o_read_data      (rdata_nz),
        .dump             (dif_nz)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] a, input logic [B-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic set_rd(input logic [W-1:0] a0, input logic [W-1:0] a1);
        raddr = {a1, a0};
    endtask

    function automatic logic [B-1:0] port(input logic [NR*B-1:0] v, input int k);
        return v[k*B +: B];
    endfunction

    function automatic logic [B-1:0] restart_exp(input int i);
        if (i == 1)  return 32'h0000_0101;
        if (i == 31) return 32'h0000_0ABC;
        return '0;
    endfunction

    initial begin
        int beats;
        int dones;
        int done_cyc;
        logic [B-1:0] col_exp;
        logic [B-1:0] col0_nz_exp;

        dif.dump_start    = 1'b0;
        dif.dump_ready    = 1'b0;
        dif_nz.dump_start = 1'b0;
        dif_nz.dump_ready = 1'b0;

        // Reset state
        #2 i_reset_n = 1'b0;
        #10;
        check("rst rdata", rdata, 0);
        check("rst valid", dif.dump_valid, 0);
        check("rst addr", dif.dump_addr, 0);
        check("rst busy", dif.dump_busy, 0);
        check("rst done", dif.dump_done, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();

        // Write then read with one-cycle latency on both ports
        wr(5, 32'hDEAD_BEEF);
        set_rd(5, 5);
        check("r5 before edge", port(rdata, 0), 0);
        tick();
        check("r5 port0", port(rdata, 0), 32'hDEAD_BEEF);
        check("r5 port1", port(rdata, 1), 32'hDEAD_BEEF);

        // Zero register vs ordinary register 0
        wr(0, 32'h1234_5678);
        set_rd(0, 5);
        tick();
        check("r0 zero_reg", port(rdata, 0), 0);
        check("r0 no zero_reg", port(rdata_nz, 0), 32'h1234_5678);
        check("r5 port1 again", port(rdata, 1), 32'hDEAD_BEEF);

        // Same-cycle write/read collision
`ifdef REGFILE_WRITE_BYPASS_EN
        col_exp     = 32'hA5A5_A5A5;
        col0_nz_exp = 32'hCAFE_F00D;
`else
        col_exp     = 32'h0000_0011;
        col0_nz_exp = 32'h1234_5678;
`endif
        wr(7, 32'h0000_0011);
        we = 1'b1; waddr = 7; wdata = 32'hA5A5_A5A5;
        set_rd(7, 5);
        tick();
        we = 1'b0;
        check("collision r7", port(rdata, 0), col_exp);
        check("collision other port", port(rdata, 1), 32'hDEAD_BEEF);
        tick();
        check("r7 after write", port(rdata, 0), 32'hA5A5_A5A5);
        we = 1'b1; waddr = 0; wdata = 32'hCAFE_F00D;
        set_rd(0, 0);
        tick();
        we = 1'b0;
        check("collision r0 zero_reg", port(rdata, 0), 0);
        check("collision r0 no zero_reg", port(rdata_nz, 0), col0_nz_exp);

        // Dump with ready toggling, a stray start mid-dump, and a write at beat 20's edge
        for (int i = 1; i < DEPTH; i++) begin
            wr(W'(i), B'(i * 3));
        end
        dif.dump_start = 1'b1;
        tick();
        dif.dump_start = 1'b0;
        check("busy after start", dif.dump_busy, 1);
        beats = 0;
        dones = 0;
        for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
            dif.dump_ready = (cyc % 2) == 1;
            dif.dump_start = (cyc == 6);
            if (dif.dump_valid && dif.dump_ready) begin
                check("bp beat addr", dif.dump_addr, beats);
                check("bp beat data", dif.dump_data, beats * 3);
                if (beats == 20) begin
                    we = 1'b1; waddr = 20; wdata = 32'h0000_FFFF;
                end
                beats++;
            end
            tick();
            we = 1'b0;
            dif.dump_start = 1'b0;
            if (dif.dump_done) dones++;
        end
        check("bp beat count", beats, DEPTH);
        check("bp done seen", dones, 1);
        check("done valid low", dif.dump_valid, 0);
        tick();
        check("done one cycle", dif.dump_done, 0);
        check("idle busy", dif.dump_busy, 0);
        set_rd(20, 3);
        tick();
        check("r20 written during dump", port(rdata, 0), 32'h0000_FFFF);
        check("r3 preload", port(rdata, 1), 9);

        // Abort by reset after beat 10
        dif.dump_ready = 1'b1;
        dif.dump_start = 1'b1;
        tick();
        dif.dump_start = 1'b0;
        beats = 0;
        for (int c = 0; c < 20 && beats < 10; c++) begin
            if (dif.dump_valid && dif.dump_ready) beats++;
            tick();
        end
        check("abort beats before reset", beats, 10);
        check("abort read data live", port(rdata, 0), 32'h0000_FFFF);
        #3 i_reset_n = 1'b0;
        #1;
        check("abort valid", dif.dump_valid, 0);
        check("abort busy", dif.dump_busy, 0);
        check("abort addr", dif.dump_addr, 0);
        check("abort rdata", rdata, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        dones = 0;
        set_rd(20, 3);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dif.dump_done) dones++;
        end
        check("abort no done", dones, 0);
        check("abort r20 cleared", port(rdata, 0), 0);
        check("abort r3 cleared", port(rdata, 1), 0);

        // Restart from address 0 with ready held high; done in cycle 2**W+1
        wr(1, 32'h0000_0101);
        wr(31, 32'h0000_0ABC);
        dif.dump_start = 1'b1;
        tick();
        dif.dump_start = 1'b0;
        beats    = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc < 100; cyc++) begin
            if (dif.dump_done) begin
                done_cyc = cyc;
                break;
            end
            if (dif.dump_valid && dif.dump_ready) begin
                check("restart addr", dif.dump_addr, beats);
                check("restart data", dif.dump_data, restart_exp(beats));
                beats++;
            end
            tick();
        end
        check("restart beat count", beats, DEPTH);
        check("restart done cycle", done_cyc, DEPTH + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
